// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered 8-to-3 priority encoder with handshake.
package prio_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // One-hot mask for a code, used to retire the bit just accepted.
  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc8_comb.sv
// Combinational 8-to-3 priority winner with a non-zero flag.
module prio_enc8_comb
  import prio_enc_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  mask,
  output logic [CODE_W-1:0] code,
  output logic              nz
);

  // Scan toward the highest-priority end so the last hit seen wins.
  always_comb begin
    // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
    code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (HIGH_FIRST) begin
        if (mask[i]) code = CODE_W'(i);
      end else begin
        if (mask[N_REQ-1-i]) code = CODE_W'(N_REQ-1-i);
      end
    end
  end

  assign nz = |mask;

endmodule

// File: rtl/prio_encoder8_hs.sv
// Registered 8-to-3 priority encoder: gathers requests into a pending mask and
// hands out one code per valid/ready handshake on the {E,x0,x1} triple.
module prio_encoder8_hs
  import prio_enc_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1,
  parameter bit MERGE      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic             E,
  output logic             x0,
  output logic             x1,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             dropped
);

  state_t              r_state;
  logic [N_REQ-1:0]    r_pend;
  logic [CODE_W-1:0]   r_code;
  logic                r_dropped;

  logic [N_REQ-1:0]    w_in;
  logic [N_REQ-1:0]    w_merge_in;
  logic [N_REQ-1:0]    w_pend_next;
  logic                w_accept;
  logic [CODE_W-1:0]   w_in_code;
  logic                w_in_nz;
  logic [CODE_W-1:0]   w_next_code;
  logic                w_next_nz;

  assign w_in       = req & {N_REQ{en}};
  assign w_merge_in = MERGE ? w_in : '0;
  assign w_accept   = (r_state == SERVE) && ready;

  // Retiring the accepted bit before OR-ing new requests lets a same-cycle
  // request for that code re-queue it.
  assign w_pend_next = w_accept ? ((r_pend & ~code_to_onehot(r_code)) | w_merge_in)
                                : (r_pend | w_merge_in);

  prio_enc8_comb #(.HIGH_FIRST(HIGH_FIRST)) u_win_in (
    .mask (w_in),
    .code (w_in_code),
    .nz   (w_in_nz)
  );

  prio_enc8_comb #(.HIGH_FIRST(HIGH_FIRST)) u_win_next (
    .mask (w_pend_next),
    .code (w_next_code),
    .nz   (w_next_nz)
  );

  // Handshake FSM: the code register only changes on load or accept, so the
  // output stays stable under backpressure even when higher requests merge in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register update using pre-edge values.
      r_state   <= IDLE;
      r_pend    <= '0;
      r_code    <= '0;
      r_dropped <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_in_nz) begin
            r_pend  <= w_in;
            r_code  <= w_in_code;
            r_state <= SERVE;
          end
        end
        SERVE: begin
          if (!MERGE && w_in_nz) r_dropped <= 1'b1;
          r_pend <= w_pend_next;
          if (w_accept) begin
            if (w_next_nz) r_code  <= w_next_code;
            else           r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {E, x0, x1} = r_code;
  assign valid       = (r_state == SERVE);
  assign busy        = (r_state == SERVE);
  assign dropped     = r_dropped;

endmodule

// File: tb/tb_prio_encoder8_hs.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized stimulus against a behavioural model, on two parameterisations.
module tb_prio_encoder8_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b0;

  logic a_E, a_x0, a_x1, a_valid, a_busy, a_dropped;
  logic b_E, b_x0, b_x1, b_valid, b_busy, b_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_encoder8_hs #(.HIGH_FIRST(1'b1), .MERGE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .E(a_E), .x0(a_x0), .x1(a_x1),
    .valid(a_valid), .ready(ready), .busy(a_busy), .dropped(a_dropped)
  );

  prio_encoder8_hs #(.HIGH_FIRST(1'b0), .MERGE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .E(b_E), .x0(b_x0), .x1(b_x1),
    .valid(b_valid), .ready(ready), .busy(b_busy), .dropped(b_dropped)
  );

  // Observed outputs packed as {valid, busy, code[2:0], dropped}.
  wire [5:0] a_obs = {a_valid, a_busy, a_E, a_x0, a_x1, a_dropped};
  wire [5:0] b_obs = {b_valid, b_busy, b_E, b_x0, b_x1, b_dropped};

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic       serve;
    logic [7:0] pend;
    logic [2:0] code;
    logic       dropped;
  } model_t;

  model_t ma, mb;

  // Winner by arithmetic: highest set bit via log2, lowest by isolating it.
  function automatic logic [2:0] winner(input logic [7:0] m, input bit hf);
    int v;
    int iso;
    v = int'(m);
    if (hf) return 3'($clog2(v + 1) - 1);
    iso = v & (-v);
    return 3'($clog2(iso));
  endfunction

  function automatic model_t mstep(input model_t m, input bit hf, input bit mg,
                                   input bit r, input bit e, input logic [7:0] q,
                                   input bit rd);
    logic [7:0] in_m;
    logic [7:0] p;
    model_t     n;
    n = m;
    if (r) return '0;
    in_m = e ? q : 8'h00;
    if (!m.serve) begin
      if (in_m != 0) begin
        n.serve = 1'b1;
        n.pend  = in_m;
        n.code  = winner(in_m, hf);
      end
    end else begin
      if (!mg && in_m != 0) n.dropped = 1'b1;
      p = m.pend;
      if (rd) p[m.code] = 1'b0;
      if (mg) p = p | in_m;
      n.pend = p;
      if (rd) begin
        if (p != 0) n.code  = winner(p, hf);
        else        n.serve = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [5:0] mexp(input model_t m);
    return {m.serve, m.serve, m.code, m.dropped};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,b,code,drop}=%b_%b_%0d_%b expected %b_%b_%0d_%b",
               name, act[5], act[4], act[3:1], act[0], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  // Apply one cycle of inputs, advance both models, sample at the next falling edge.
  task automatic cyc(input bit r, input bit e, input logic [7:0] q, input bit rd);
    rst   = r;
    en    = e;
    req   = q;
    ready = rd;
    ma = mstep(ma, 1'b1, 1'b1, r, e, q, rd);
    mb = mstep(mb, 1'b0, 1'b0, r, e, q, rd);
    @(negedge clk);
  endtask

  // ---------------- directed vector table (dut_a) ----------------
  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic r, input logic e,
                              input logic [7:0] q, input logic rd,
                              input logic v, input logic [2:0] c);
    vec_t t;
    t.name = nm; t.rst = r; t.en = e; t.req = q; t.ready = rd;
    t.exp_valid = v; t.exp_code = c;
    return t;
  endfunction

  initial begin
    ma = '0;
    mb = '0;

    // Reset with all requests asserted, then release.
    tbl.push_back(mk("reset0",       1, 1, 8'hFF, 0, 0, 3'd0));
    tbl.push_back(mk("reset1",       1, 1, 8'hFF, 0, 0, 3'd0));
    tbl.push_back(mk("release_c7",   0, 1, 8'hFF, 0, 1, 3'd7));
    tbl.push_back(mk("reset_clear",  1, 0, 8'h00, 0, 0, 3'd0));
    // Multi-hot drain with ready held high.
    tbl.push_back(mk("drain_c7",     0, 1, 8'hA4, 1, 1, 3'd7));
    tbl.push_back(mk("drain_c5",     0, 1, 8'h00, 1, 1, 3'd5));
    tbl.push_back(mk("drain_c2",     0, 1, 8'h00, 1, 1, 3'd2));
    tbl.push_back(mk("drain_idle",   0, 1, 8'h00, 1, 0, 3'd2));
    tbl.push_back(mk("drain_idle2",  0, 1, 8'h00, 1, 0, 3'd2));
    // Backpressure: code 0 must stay put while code 7 merges in.
    tbl.push_back(mk("bp_load_c0",   0, 1, 8'h01, 0, 1, 3'd0));
    tbl.push_back(mk("bp_hold1",     0, 1, 8'h00, 0, 1, 3'd0));
    tbl.push_back(mk("bp_hold2",     0, 1, 8'h00, 0, 1, 3'd0));
    tbl.push_back(mk("bp_hold3",     0, 1, 8'h00, 0, 1, 3'd0));
    tbl.push_back(mk("bp_merge_80",  0, 1, 8'h80, 0, 1, 3'd0));
    tbl.push_back(mk("bp_hold4",     0, 1, 8'h00, 0, 1, 3'd0));
    tbl.push_back(mk("bp_acc_c7",    0, 1, 8'h00, 1, 1, 3'd7));
    tbl.push_back(mk("bp_idle",      0, 1, 8'h00, 1, 0, 3'd7));
    // Re-queue: accepting code 2 while req[2] is set serves it again.
    tbl.push_back(mk("rq_load_c2",   0, 1, 8'h04, 0, 1, 3'd2));
    tbl.push_back(mk("rq_collide",   0, 1, 8'h04, 1, 1, 3'd2));
    tbl.push_back(mk("rq_again_idle",0, 1, 8'h00, 1, 0, 3'd2));
    // en low masks requests entirely.
    tbl.push_back(mk("en_low",       0, 0, 8'hFF, 1, 0, 3'd2));
    // Reset mid-operation after two accepts.
    tbl.push_back(mk("mid_c7",       0, 1, 8'hF0, 1, 1, 3'd7));
    tbl.push_back(mk("mid_c6",       0, 1, 8'h00, 1, 1, 3'd6));
    tbl.push_back(mk("mid_c5",       0, 1, 8'h00, 1, 1, 3'd5));
    tbl.push_back(mk("mid_rst",      1, 1, 8'h00, 1, 0, 3'd0));
    tbl.push_back(mk("post_rst1",    0, 1, 8'h00, 1, 0, 3'd0));
    tbl.push_back(mk("post_rst2",    0, 1, 8'h00, 1, 0, 3'd0));
    tbl.push_back(mk("post_rst3",    0, 1, 8'h00, 1, 0, 3'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].ready);
      check(tbl[i].name, a_obs,
            {tbl[i].exp_valid, tbl[i].exp_valid, tbl[i].exp_code, 1'b0});
    end

    // ---------------- MERGE=0 drop sequence (dut_b) ----------------
    cyc(1, 0, 8'h00, 0);
    check("drop_reset", b_obs, 6'b00_000_0);
    cyc(0, 1, 8'h08, 0);
    check("drop_load_c3", b_obs, {2'b11, 3'd3, 1'b0});
    cyc(0, 1, 8'h10, 0);
    check("drop_set", b_obs, {2'b11, 3'd3, 1'b1});
    cyc(0, 1, 8'h00, 1);
    check("drop_after_acc", b_obs, {2'b00, 3'd3, 1'b1});
    check("merge_a_c4", a_obs, {2'b11, 3'd4, 1'b0});
    cyc(0, 1, 8'h00, 1);
    check("drop_sticky", b_obs, {2'b00, 3'd3, 1'b1});
    // Low-first winner: 0x28 on dut_b serves 3 then 5.
    cyc(0, 1, 8'h28, 1);
    check("lowfirst_c3", b_obs, {2'b11, 3'd3, 1'b1});
    cyc(0, 1, 8'h00, 1);
    check("lowfirst_c5", b_obs, {2'b11, 3'd5, 1'b1});
    cyc(0, 1, 8'h00, 1);
    check("lowfirst_idle", b_obs, {2'b00, 3'd5, 1'b1});
    cyc(1, 0, 8'h00, 0);
    check("drop_cleared", b_obs, 6'b00_000_0);

    // ---------------- randomized stimulus vs model ----------------
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic       e;
      logic [7:0] q;
      logic       rd;
      r  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      q  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 3) == 0) q = 8'h00;
      rd = ($urandom_range(0, 1) == 1);
      cyc(r, e, q, rd);
      check("rand_a", a_obs, mexp(ma));
      check("rand_b", b_obs, mexp(mb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
